// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 8-bit unsigned restoring divider, one quotient bit per clock
module seq_divider #(
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic       CLK,
   input  logic       RESET_bar,
   input  logic       START,
   input  logic [7:0] DIVIDEND,
   input  logic [7:0] DIVISOR,
   output logic [7:0] QUOTIENT,
   output logic [7:0] REMAINDER,
   output logic       BUSY,
   output logic       DONE,
   output logic       DIV_ZERO
);

   typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

   state_t     state;
   logic [7:0] dvd_sr;
   logic [7:0] divisor_r;
   logic [8:0] prem;
   logic [3:0] count;

   logic [8:0] shifted;
   logic [9:0] trial;
   logic       no_borrow;
   logic [8:0] next_prem;
   logic [7:0] next_sr;

   // Output delays only matter to a timing-annotated model; the logic itself is zero-delay.
   wire unused_delay = (DELAY_RISE != DELAY_FALL);

   // Trial subtraction as add of inverted divisor with carry-in; carry-out set means no borrow.
   assign shifted   = {prem[7:0], dvd_sr[7]};
   assign trial     = {1'b0, shifted} + {2'b01, ~divisor_r} + 10'd1;
   assign no_borrow = trial[9];
   assign next_prem = no_borrow ? trial[8:0] : shifted;
   assign next_sr   = {dvd_sr[6:0], no_borrow};

   always_ff @(posedge CLK or negedge RESET_bar) begin
      if (!RESET_bar) begin
         state     <= IDLE;
         dvd_sr    <= '0;
         divisor_r <= '0;
         prem      <= '0;
         count     <= '0;
         QUOTIENT  <= '0;
         REMAINDER <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         DIV_ZERO  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE_ST: begin
               if (START) begin
                  dvd_sr    <= DIVIDEND;
                  divisor_r <= DIVISOR;
                  prem      <= '0;
                  count     <= '0;
                  BUSY      <= 1'b1;
                  DONE      <= 1'b0;
                  DIV_ZERO  <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               dvd_sr <= next_sr;
               prem   <= next_prem;
               count  <= count + 4'd1;
               if (count == 4'd7) begin
                  QUOTIENT  <= next_sr;
                  REMAINDER <= next_prem[7:0];
                  DIV_ZERO  <= (divisor_r == 8'd0);
                  BUSY      <= 1'b0;
                  DONE      <= 1'b1;
                  state     <= DONE_ST;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
            end
         endcase
      end
   end

endmodule
